shift_sequencer: RTL

//  Iterative 32-bit shift unit in the ALU shift path, feeding the fixed-distance shift stages.
//  - Per operation: SLL or SRA of a 32-bit operand by shamt[4:0].
//  - Applies one power-of-two stage per clock: 16, 8, 4, 2, then 1.
//  - Uses start/busy/done handshaking toward the ALU/issue controller.
//  - Trades a single-cycle barrel shifter for a registered multi-cycle path.

---
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between the ALU/issue controller (master) and
// the iterative shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, in_data, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, in_data, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRA unit: one power-of-two stage (16,8,4,2,1) per clock.
// Optional macro SHIFT_EARLY_EXIT_EN finishes once no lower shamt bits remain.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic              clock,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  localparam int K_W = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy, done, last;

  // SRA replicates the current top bit of the accumulator.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] a,
                                                   input logic             sra,
                                                   input logic [K_W-1:0]   k);
    logic signed [WIDTH-1:0] s;
    s = a;
    if (sra) stage_shift = s >>> (1 << k);
    else     stage_shift = a << (1 << k);
  endfunction

`ifdef SHIFT_EARLY_EXIT_EN
  function automatic logic [SHW-1:0] low_mask(input logic [K_W-1:0] k);
    low_mask = SHW'((1 << k) - 1);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    shamt_d  = shamt_q;
    op_d     = op_q;
    result_d = result_q;
    busy     = 1'b0;
    done     = 1'b0;
    last     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (bus.start) begin
          acc_d   = bus.in_data;
          shamt_d = bus.shamt;
          op_d    = bus.op;
          k_d     = K_W'(SHW - 1);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (shamt_q[k_q]) acc_d = stage_shift(acc_q, op_q, k_q);
`ifdef SHIFT_EARLY_EXIT_EN
        last = (k_q == '0) || ((shamt_q & low_mask(k_q)) == '0);
`else
        last = (k_q == '0);
`endif
        if (last) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result reset; the working operands do not need to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= K_W'(SHW - 1);
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clock) begin
    acc_q   <= acc_d;
    shamt_q <= shamt_d;
    op_q    <= op_d;
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;

endmodule
